// File: rtl/ams_pwm_dac.sv
// PWM DAC stage: 8-bit base duty plus a 16-period dither mask.
// The dither adds about 4 bits of effective resolution after RC filtering.
module ams_pwm_dac #(
  parameter int FULL = 156
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [23:0] cfg_i,
  output logic        pwm_o,
  output logic        frame_o
);

  localparam logic [7:0] LAST = 8'(FULL - 1);

  logic [7:0]  cnt;
  logic [3:0]  prd;
  logic [7:0]  base_r;
  logic [15:0] mask_r;
  logic [8:0]  duty_r;
  logic        wrap;
  logic        fr_end;

  assign wrap   = (cnt == LAST);
  assign fr_end = wrap && (prd == 4'hf);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt     <= LAST;
      prd     <= 4'hf;
      base_r  <= '0;
      mask_r  <= '0;
      duty_r  <= '0;
      pwm_o   <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      // 9-bit compare: duty of FULL or more holds the output high all period
      pwm_o   <= ({1'b0, cnt} < duty_r);
      frame_o <= fr_end;
      if (wrap) begin
        cnt <= '0;
        prd <= prd + 4'd1;
        if (fr_end) begin
          base_r <= cfg_i[23:16];
          mask_r <= cfg_i[15:0];
          duty_r <= {1'b0, cfg_i[23:16]} + {8'd0, cfg_i[0]};
        end else begin
          // bit 1 of the unshifted mask is the dither bit of the next period
          mask_r <= mask_r >> 1;
          duty_r <= {1'b0, base_r} + {8'd0, mask_r[1]};
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Directed bench for ams_pwm_dac: per-period high counts,
// frame strobes, mid-frame config changes and async reset.
module tb_ams_pwm_dac;

  localparam int FULL  = 156;
  localparam int FRAME = 16 * FULL;

  logic        clk_i;
  logic        rstn_i;
  logic [23:0] cfg_i;
  logic        pwm_o;
  logic        frame_o;

  ams_pwm_dac #(.FULL(FULL)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .cfg_i   (cfg_i),
    .pwm_o   (pwm_o),
    .frame_o (frame_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [23:0] cfg;
    int          p0;
    int          p1;
    int          tot;
  } vec_t;

  vec_t vecs[7];

  int   nchk;
  int   nerr;
  int   per[16];
  int   tot;
  int   frm;
  logic last_frm;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reset with cfg applied, release, and stop just after edge 1
  task automatic do_reset(input logic [23:0] cfg);
    cfg_i  = cfg;
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Sample one frame-length window, one sample per clock
  task automatic measure(input int chg_idx, input logic [23:0] chg_val);
    for (int k = 0; k < 16; k++) per[k] = 0;
    tot      = 0;
    frm      = 0;
    last_frm = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk_i);
      #1;
      if (i == chg_idx) cfg_i = chg_val;
      per[i / FULL] += int'(pwm_o);
      tot += int'(pwm_o);
      frm += int'(frame_o);
      if (i == FRAME - 1) last_frm = frame_o;
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;

    vecs[0] = '{24'h000000, 0,   0,   0};
    vecs[1] = '{24'h0F0000, 15,  15,  240};
    vecs[2] = '{24'h4E5555, 79,  78,  1256};
    vecs[3] = '{24'hFFFFFF, 156, 156, 2496};
    vecs[4] = '{24'h010001, 2,   1,   17};
    vecs[5] = '{24'h9B8000, 155, 155, 2481};
    vecs[6] = '{24'hFF0000, 156, 156, 2496};

    cfg_i  = 24'h000000;
    rstn_i = 1'b0;
    #3;
    chk("reset_pwm", int'(pwm_o), 0);
    chk("reset_frame", int'(frame_o), 0);

    for (int v = 0; v < 7; v++) begin
      do_reset(vecs[v].cfg);
      chk($sformatf("v%0d_frame_e1", v), int'(frame_o), 1);
      chk($sformatf("v%0d_pwm_e1", v), int'(pwm_o), 0);
      measure(-1, 24'h0);
      chk($sformatf("v%0d_p0", v), per[0], vecs[v].p0);
      chk($sformatf("v%0d_p1", v), per[1], vecs[v].p1);
      chk($sformatf("v%0d_total", v), tot, vecs[v].tot);
      chk($sformatf("v%0d_frames", v), frm, 1);
      chk($sformatf("v%0d_next_frame", v), int'(last_frm), 1);
    end
    chk("v5_p15", per[15], 156);

    // Mid-frame change is held off until the next frame boundary
    do_reset(24'h0F0000);
    chk("chg_frame_e1", int'(frame_o), 1);
    measure(7 * FULL + 40, 24'h9C0000);
    chk("chg_p0", per[0], 15);
    chk("chg_p7", per[7], 15);
    chk("chg_p15", per[15], 15);
    chk("chg_total", tot, 240);
    chk("chg_strobe", int'(last_frm), 1);
    measure(-1, 24'h0);
    chk("chg_new_p0", per[0], 156);
    chk("chg_new_p15", per[15], 156);
    chk("chg_new_total", tot, 2496);
    chk("chg_new_frames", frm, 1);

    // Async reset in the middle of a high phase
    do_reset(24'h4E5555);
    repeat (9) begin
      @(posedge clk_i);
      #1;
    end
    chk("ar_pwm_high", int'(pwm_o), 1);
    #1;
    rstn_i = 1'b0;
    #1;
    chk("ar_pwm_low", int'(pwm_o), 0);
    chk("ar_frame_low", int'(frame_o), 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ar_frame_e1", int'(frame_o), 1);
    measure(-1, 24'h0);
    chk("ar_p0", per[0], 79);
    chk("ar_p1", per[1], 78);
    chk("ar_total", tot, 1256);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
